// File: rtl/hilo_div_unit_if.sv
// hilo_div_unit_if
// Request/result bundle between the EX stage and the HI/LO divide unit.
//   master : EX-stage side, drives Start/Op/A/B/ALUHi/ALULo and observes
//            Hi/Lo/Busy/Done/DivByZero.
//   slave  : the hilo_div_unit itself.
interface hilo_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [2:0]            Op;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [DATA_WIDTH-1:0] ALUHi;
    logic [DATA_WIDTH-1:0] ALULo;
    logic [DATA_WIDTH-1:0] Hi;
    logic [DATA_WIDTH-1:0] Lo;
    logic                  Busy;
    logic                  Done;
    logic                  DivByZero;

    modport master (
        output Start, Op, A, B, ALUHi, ALULo,
        input  Hi, Lo, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, Op, A, B, ALUHi, ALULo,
        output Hi, Lo, Busy, Done, DivByZero
    );
endinterface

// File: rtl/hilo_div_unit.sv
// hilo_div_unit
// HI/LO register file with an iterative restoring divider (DIV/DIVU),
// plus single-cycle MTHI, MTLO and MULT product load.
// Ports:
//   Clk    : rising-edge clock
//   Reset  : asynchronous active-high reset, clears all state
//   bus    : request (Start, Op, A, B, ALUHi, ALULo) and result
//            (Hi, Lo, Busy, Done, DivByZero) bundle, slave side
module hilo_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    hilo_div_unit_if.slave       bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MLOAD = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement negate when en is set, otherwise pass through.
    function automatic logic [DATA_WIDTH-1:0] cond_neg(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  en
    );
        if (en) begin
            cond_neg = ~v + DATA_WIDTH'(1);
        end else begin
            cond_neg = v;
        end
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;   // dividend bits out, quotient bits in
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
    logic [DATA_WIDTH-1:0] rem_q, rem_d;   // partial remainder (always < divisor)
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dbz_q, dbz_d;

    logic                  is_div_s;
    logic [DATA_WIDTH:0]   rem_shift_s;

    // Next-state logic for the FSM, datapath and HI/LO registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        is_div_s    = (bus.Op == OP_DIV);
        // Partial remainder is < divisor, so its shifted form fits in W+1 bits.
        rem_shift_s = {rem_q, dvd_q[DATA_WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        OP_DIV, OP_DIVU: begin
                            // Magnitudes wrap: |0x80000000| stays 0x80000000.
                            dvd_d   = cond_neg(bus.A, is_div_s && bus.A[DATA_WIDTH-1]);
                            dvs_d   = cond_neg(bus.B, is_div_s && bus.B[DATA_WIDTH-1]);
                            qneg_d  = is_div_s && (bus.A[DATA_WIDTH-1] ^ bus.B[DATA_WIDTH-1]);
                            rneg_d  = is_div_s && bus.A[DATA_WIDTH-1];
                            rem_d   = '0;
                            cnt_d   = CW'(DATA_WIDTH - 1);
                            state_d = S_RUN;
                        end
                        OP_MTHI: begin
                            hi_d = bus.A;
                        end
                        OP_MTLO: begin
                            lo_d = bus.A;
                        end
                        OP_MLOAD: begin
                            hi_d = bus.ALUHi;
                            lo_d = bus.ALULo;
                        end
                        default: begin
                            hi_d = hi_q;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Restoring step; the freed LSB of dvd collects the quotient bit.
                if (rem_shift_s >= {1'b0, dvs_q}) begin
                    rem_d = rem_shift_s[DATA_WIDTH-1:0] - dvs_q;
                    dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift_s[DATA_WIDTH-1:0];
                    dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(0)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                lo_d    = cond_neg(dvd_q, qneg_q);
                hi_d    = cond_neg(rem_q, rneg_q);
                dbz_d   = (dvs_q == '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; async reset aborts any divide in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit
// Directed, table-driven bench for hilo_div_unit: divide vectors with
// hand-computed results, single-cycle HI/LO ops, Start-while-Busy,
// back-to-back divides and asynchronous reset in the middle of a divide.
module tb_hilo_div_unit;
    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    hilo_div_unit_if #(.DATA_WIDTH(32)) bus ();

    hilo_div_unit #(.DATA_WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic        exp_dbz;
    } div_vec_t;

    div_vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issue one divide, check Busy length and the result at the Done cycle.
    // Returns in the cycle where Done is high, before the following edge.
    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dbz, input string name);
        int cyc;
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        cyc = 0;
        while (bus.Busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(posedge Clk);
            #1;
        end
        chk({name, "_busy_cycles"}, 32'(cyc), 32'd33);
        chk({name, "_done"}, {31'd0, bus.Done}, 32'd1);
        chk({name, "_lo"}, bus.Lo, exp_lo);
        chk({name, "_hi"}, bus.Hi, exp_hi);
        chk({name, "_dbz"}, {31'd0, bus.DivByZero}, {31'd0, exp_dbz});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{3'b000, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
        vecs[1] = '{3'b000, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2] = '{3'b001, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          1'b0};
        vecs[3] = '{3'b000, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[4] = '{3'b001, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[5] = '{3'b001, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[6] = '{3'b000, 32'hFFFFFFF9,   32'd0,          32'd1,          32'hFFFFFFF9,   1'b1};
        vecs[7] = '{3'b000, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};

        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.ALUHi = 32'd0;
        bus.ALULo = 32'd0;
        Reset     = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_hi",   bus.Hi, 32'd0);
        chk("rst_lo",   bus.Lo, 32'd0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_dbz",  {31'd0, bus.DivByZero}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Divide vectors; Done must drop after exactly one cycle.
        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_lo, vecs[i].exp_hi,
                    vecs[i].exp_dbz, $sformatf("vec%0d", i));
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, bus.Done}, 32'd0);
        end

        // MULTLOAD, MTHI, MTLO: one-edge updates, Busy stays low.
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 3'b100; bus.ALUHi = 32'h1; bus.ALULo = 32'h2;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        chk("mload_hi", bus.Hi, 32'h1);
        chk("mload_lo", bus.Lo, 32'h2);
        chk("mload_busy", {31'd0, bus.Busy}, 32'd0);
        chk("mload_done", {31'd0, bus.Done}, 32'd0);
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 3'b010; bus.A = 32'hCAFE0001;
        @(posedge Clk); #1;
        chk("mthi_hi", bus.Hi, 32'hCAFE0001);
        chk("mthi_lo", bus.Lo, 32'h2);
        @(negedge Clk);
        bus.Op = 3'b011; bus.A = 32'h0BADF00D;
        @(posedge Clk); #1;
        chk("mtlo_lo", bus.Lo, 32'h0BADF00D);
        chk("mtlo_hi", bus.Hi, 32'hCAFE0001);
        @(negedge Clk);
        bus.Op = 3'b111; bus.A = 32'h12345678;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        chk("rsv_hi", bus.Hi, 32'hCAFE0001);
        chk("rsv_lo", bus.Lo, 32'h0BADF00D);
        chk("rsv_busy", {31'd0, bus.Busy}, 32'd0);

        // Start while Busy: MTHI at cycle 5 of RUN is ignored.
        fork
            run_div(3'b000, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "busy_mthi");
            begin
                repeat (6) @(posedge Clk);
                @(negedge Clk);
                bus.Start = 1'b1; bus.Op = 3'b010; bus.A = 32'hDEAD;
                @(posedge Clk); #1;
                bus.Start = 1'b0;
                chk("busy_hold_hi", bus.Hi, 32'hCAFE0001);
                chk("busy_hold_lo", bus.Lo, 32'h0BADF00D);
            end
        join

        // Back-to-back: second Start issued while Done is high.
        run_div(3'b001, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, "b2b_a");
        run_div(3'b001, 32'd21, 32'd4, 32'd5, 32'd1, 1'b0, "b2b_b");

        // Async reset mid-RUN: immediate clear, and no Done afterwards.
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 3'b001; bus.A = 32'd50; bus.B = 32'd3;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("midrst_hi",   bus.Hi, 32'd0);
        chk("midrst_lo",   bus.Lo, 32'd0);
        chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge Clk); #1;
                if (bus.Done === 1'b1 || bus.Busy === 1'b1) seen_done = 1;
            end
            chk("midrst_no_done", 32'(seen_done), 32'd0);
        end
        chk("midrst_hi_after", bus.Hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
